// File: rtl/wrapper_sha256_pkg.sv
// ---------------------------------------------------------------------------
// wrapper_sha256_pkg: shared types and constants for the SHA-256 padder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wrapper_sha256_pkg;

  localparam int SHA_BLOCK_W   = 512;
  localparam int SHA_LEN_W     = 64;
  // Largest tail that still leaves room for the marker bit and the length field.
  localparam int SHA_PAD_LIMIT = 447;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    PAD_ONE  = 2'd2,
    LEN_ONLY = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    MODE_PASS       = 3'd0,
    MODE_TAIL_FIT   = 3'd1,
    MODE_TAIL_SPLIT = 3'd2,
    MODE_PAD_ONE    = 3'd3,
    MODE_LEN_ONLY   = 3'd4
  } pad_mode_e;

endpackage

`default_nettype wire

// File: rtl/wrapper_sha256_pad_block.sv
// ---------------------------------------------------------------------------
// wrapper_sha256_pad_block: builds one output block from data, tail length and mode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrapper_sha256_pad_block
  import wrapper_sha256_pkg::*;
(
  input  logic [SHA_BLOCK_W-1:0] data,
  input  logic [9:0]             r,
  input  logic [SHA_LEN_W-1:0]   len,
  input  pad_mode_e              mode,
  output logic [SHA_BLOCK_W-1:0] pad_out
);

  logic [SHA_BLOCK_W-1:0] keep_mask;
  logic [SHA_BLOCK_W-1:0] marker;
  logic [SHA_BLOCK_W-1:0] len_field;
  logic [SHA_BLOCK_W-1:0] top_bit;

  assign top_bit   = {1'b1, {(SHA_BLOCK_W-1){1'b0}}};
  // Message bits fill from the MSB down, so a tail of r bits keeps the top r positions.
  assign keep_mask = ~({SHA_BLOCK_W{1'b1}} >> r);
  assign marker    = top_bit >> r;
  assign len_field = {{(SHA_BLOCK_W-SHA_LEN_W){1'b0}}, len};

  always_comb begin
    pad_out = data;
    case (mode)
      MODE_PASS:       pad_out = data;
      MODE_TAIL_FIT:   pad_out = (data & keep_mask) | marker | len_field;
      MODE_TAIL_SPLIT: pad_out = (data & keep_mask) | marker;
      MODE_PAD_ONE:    pad_out = top_bit | len_field;
      MODE_LEN_ONLY:   pad_out = len_field;
      default:         pad_out = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wrapper_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// wrapper_sha256_msg_padder: FIPS 180-4 message padder in front of the SHA-256 engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrapper_sha256_msg_padder
  import wrapper_sha256_pkg::*;
#(
  parameter int PACKETWIDTH  = 512,
  parameter int CFGSIZEWIDTH = 64
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [CFGSIZEWIDTH-1:0] cfg_size,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PACKETWIDTH-1:0]  in_packet,
  input  logic                    in_packet_last,
  input  logic                    in_packet_valid,
  output logic                    in_packet_ready,
  output logic [PACKETWIDTH-1:0]  out_packet,
  output logic                    out_packet_last,
  output logic                    out_packet_valid,
  input  logic                    out_packet_ready,
  output logic                    busy,
  output logic                    len_err
);

  localparam logic [SHA_LEN_W-1:0] BLOCK_BITS = SHA_LEN_W'(SHA_BLOCK_W);
  localparam logic [SHA_LEN_W-1:0] PAD_LIMIT  = SHA_LEN_W'(SHA_PAD_LIMIT);

  state_e                 state_q, state_d;
  logic [SHA_LEN_W-1:0]   rem_q, rem_d;
  logic [SHA_LEN_W-1:0]   len_q, len_d;
  logic [PACKETWIDTH-1:0] out_q, out_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;
  logic                   len_err_q, len_err_d;

  logic                   can_load;
  logic                   in_fire;
  pad_mode_e              mode;
  logic [SHA_BLOCK_W-1:0] pad_out;

  assign can_load         = !out_valid_q || out_packet_ready;
  assign cfg_ready        = (state_q == IDLE);
  assign in_packet_ready  = (state_q == DATA) && can_load;
  assign in_fire          = in_packet_valid && in_packet_ready;
  assign out_packet       = out_q;
  assign out_packet_last  = out_last_q;
  assign out_packet_valid = out_valid_q;
  assign len_err          = len_err_q;
  assign busy             = (state_q != IDLE) || out_valid_q;

  always_comb begin
    mode = MODE_PASS;
    case (state_q)
      DATA: begin
        if (rem_q >= BLOCK_BITS)    mode = MODE_PASS;
        else if (rem_q > PAD_LIMIT) mode = MODE_TAIL_SPLIT;
        else                        mode = MODE_TAIL_FIT;
      end
      PAD_ONE:  mode = MODE_PAD_ONE;
      LEN_ONLY: mode = MODE_LEN_ONLY;
      default:  mode = MODE_PASS;
    endcase
  end

  wrapper_sha256_pad_block u_pad_block (
    .data    (in_packet),
    .r       (rem_q[9:0]),
    .len     (len_q),
    .mode    (mode),
    .pad_out (pad_out)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    len_d       = len_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_packet_ready;
    len_err_d   = len_err_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          len_d     = SHA_LEN_W'(cfg_size);
          rem_d     = SHA_LEN_W'(cfg_size);
          len_err_d = 1'b0;
          state_d   = (cfg_size == '0) ? PAD_ONE : DATA;
        end
      end
      DATA: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_d       = pad_out;
          if (rem_q > BLOCK_BITS) begin
            rem_d      = rem_q - BLOCK_BITS;
            out_last_d = 1'b0;
            if (in_packet_last) len_err_d = 1'b1;
          end else begin
            if (!in_packet_last) len_err_d = 1'b1;
            if (rem_q == BLOCK_BITS) begin
              out_last_d = 1'b0;
              state_d    = PAD_ONE;
            end else if (rem_q > PAD_LIMIT) begin
              out_last_d = 1'b0;
              state_d    = LEN_ONLY;
            end else begin
              out_last_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
      end
      PAD_ONE, LEN_ONLY: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_d       = pad_out;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      len_q       <= '0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wrapper_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_wrapper_sha256_msg_padder: directed scoreboard bench for the SHA-256 padder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wrapper_sha256_msg_padder;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } exp_t;

  logic         hclk;
  logic         hresetn;
  logic [63:0]  cfg_size;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [511:0] in_packet;
  logic         in_packet_last;
  logic         in_packet_valid;
  logic         in_packet_ready;
  logic [511:0] out_packet;
  logic         out_packet_last;
  logic         out_packet_valid;
  logic         out_packet_ready;
  logic         busy;
  logic         len_err;

  exp_t         exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;
  int           n_fail  = 0;
  logic         cfg_fire;
  logic         in_fire;
  logic         saw_in_ready;
  logic [511:0] p1, p2, ones;

  wrapper_sha256_msg_padder #(
    .PACKETWIDTH  (512),
    .CFGSIZEWIDTH (64)
  ) dut (
    .hclk             (hclk),
    .hresetn          (hresetn),
    .cfg_size         (cfg_size),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .in_packet        (in_packet),
    .in_packet_last   (in_packet_last),
    .in_packet_valid  (in_packet_valid),
    .in_packet_ready  (in_packet_ready),
    .out_packet       (out_packet),
    .out_packet_last  (out_packet_last),
    .out_packet_valid (out_packet_valid),
    .out_packet_ready (out_packet_ready),
    .busy             (busy),
    .len_err          (len_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, score any output handshake, return 1 after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge hclk);
    if (out_packet_valid && out_packet_ready) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_output", out_packet_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_packet, e.data);
        chk1("out_last", out_packet_last, e.last);
      end
    end
    cfg_fire = cfg_valid && cfg_ready;
    in_fire  = in_packet_valid && in_packet_ready;
    if (in_packet_ready) saw_in_ready = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [511:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send_cfg(input logic [63:0] size);
    logic ok;
    ok        = 1'b0;
    cfg_size  = size;
    cfg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_fire) begin
        ok = 1'b1;
        break;
      end
    end
    cfg_valid = 1'b0;
    chk1("cfg_accept", ok, 1'b1);
  endtask

  task automatic send_pkt(input logic [511:0] d, input logic l);
    logic ok;
    ok              = 1'b0;
    in_packet       = d;
    in_packet_last  = l;
    in_packet_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_fire) begin
        ok = 1'b1;
        break;
      end
    end
    in_packet_valid = 1'b0;
    chk1("pkt_accept", ok, 1'b1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_packet_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk1("drain", done, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk(tag, out_packet, 512'd0);
    chk1(tag, out_packet_last, 1'b0);
    chk1(tag, out_packet_valid, 1'b0);
    chk1(tag, len_err, 1'b0);
    chk1(tag, cfg_ready, 1'b1);
    chk1(tag, in_packet_ready, 1'b0);
    chk1(tag, busy, 1'b0);
  endtask

  initial begin
    hresetn          = 1'b0;
    cfg_size         = '0;
    cfg_valid        = 1'b0;
    in_packet        = '0;
    in_packet_last   = 1'b0;
    in_packet_valid  = 1'b0;
    out_packet_ready = 1'b1;
    saw_in_ready     = 1'b0;
    cfg_fire         = 1'b0;
    in_fire          = 1'b0;
    p1   = {16{32'hDEADBEEF}};
    ones = {512{1'b1}};
    p2   = ones;

    repeat (2) @(posedge hclk);
    #1;
    chk_reset_state("reset");
    @(negedge hclk);
    #2 hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // "abc"
    send_cfg(64'd24);
    push({24'h616263, 1'b1, 423'd0, 64'd24}, 1'b1);
    send_pkt({24'h616263, 488'd0}, 1'b1);
    drain();
    chk1("abc_len_err", len_err, 1'b0);

    // Empty message: only the marker/length block, no input consumed.
    saw_in_ready = 1'b0;
    send_cfg(64'd0);
    push({1'b1, 447'd0, 64'd0}, 1'b1);
    drain();
    chk1("empty_no_in_ready", saw_in_ready, 1'b0);

    // Exactly one block of data, padding goes into a second block.
    send_cfg(64'd512);
    push(ones, 1'b0);
    push({1'b1, 447'd0, 64'd512}, 1'b1);
    send_pkt(ones, 1'b1);
    drain();
    chk1("len512_len_err", len_err, 1'b0);

    // 1000 bits: tail of 488 does not leave room for the length.
    send_cfg(64'd1000);
    push(p1, 1'b0);
    send_pkt(p1, 1'b0);
    push({{489{1'b1}}, 23'd0}, 1'b0);
    push({448'd0, 64'd1000}, 1'b1);
    send_pkt(p2, 1'b1);
    drain();
    chk1("len1000_len_err", len_err, 1'b0);

    // Early last marker: len_err is sticky, output still follows cfg_size.
    send_cfg(64'd1024);
    push(p1, 1'b0);
    send_pkt(p1, 1'b1);
    chk1("early_last_len_err", len_err, 1'b1);
    push(p2, 1'b0);
    push({1'b1, 447'd0, 64'd1024}, 1'b1);
    send_pkt(p2, 1'b1);
    drain();
    chk1("len_err_sticky", len_err, 1'b1);

    // Backpressure mid-message; next cfg clears len_err.
    send_cfg(64'd1000);
    chk1("cfg_clears_len_err", len_err, 1'b0);
    out_packet_ready = 1'b0;
    push(p1, 1'b0);
    send_pkt(p1, 1'b0);
    in_packet       = p2;
    in_packet_last  = 1'b1;
    in_packet_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_valid", out_packet_valid, 1'b1);
      chk("bp_data_stable", out_packet, p1);
      chk1("bp_in_ready", in_packet_ready, 1'b0);
      chk1("bp_no_accept", in_fire, 1'b0);
    end
    in_packet_valid  = 1'b0;
    out_packet_ready = 1'b1;
    push({{489{1'b1}}, 23'd0}, 1'b0);
    push({448'd0, 64'd1000}, 1'b1);
    send_pkt(p2, 1'b1);
    drain();

    // Asynchronous reset mid-DATA drops the message.
    send_cfg(64'd1000);
    out_packet_ready = 1'b0;
    send_pkt(p1, 1'b0);
    chk1("pre_reset_valid", out_packet_valid, 1'b1);
    #2 hresetn = 1'b0;
    #1;
    chk_reset_state("async_reset");
    exp_q.delete();
    out_packet_ready = 1'b1;
    @(negedge hclk);
    #2 hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // "abc" again, with junk below the message to exercise the mask.
    send_cfg(64'd24);
    push({24'h616263, 1'b1, 423'd0, 64'd24}, 1'b1);
    send_pkt({24'h616263, {488{1'b1}}}, 1'b1);
    drain();
    chk1("abc2_len_err", len_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
